alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Command sequencer for the lab ALU datapath. It accepts operation commands over a valid/ready handshake and reads operands from a 4-entry local register file. It drives the ALU's A/B/control/flag inputs for one execute cycle, writes the result back, and returns the result and the C/Z flags over a response handshake. It sits between a host/test driver and the combinational ALU instance, which is external and connected through the `alu_*` ports.

## Interface
- `WIDTH`, 4, data width of the ALU buses, operands, immediates and register entries.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_op`  in  4  opcode: 0–9 are ALU ops passed to `alu_control`; 'hF is LOAD immediate; 'hA–'hE are illegal.
- `cmd_flag`  in  1  value for `alu_flag_in`.
- `cmd_rd`  in  2  destination register.
- `cmd_ra`  in  2  A-operand source register.
- `cmd_rb`  in  2  B-operand source register.
- `cmd_imm`  in  WIDTH  immediate, used only by LOAD.
- `alu_a`  out  WIDTH  to ALU A.
- `alu_b`  out  WIDTH  to ALU B.
- `alu_control`  out  4  to ALU control; zero-extended at the ALU boundary.
- `alu_flag_in`  out  1  to ALU flag input.
- `alu_result`  in  WIDTH  from ALU.
- `alu_c`  in  1  from ALU carry.
- `alu_z`  in  1  from ALU zero.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`.
- `rsp_result`  out  WIDTH  value written to `rd`.
- `rsp_c`  out  1  carry of the completed command.
- `rsp_z`  out  1  zero of the completed command.
- `rsp_err`  out  1  illegal-opcode indication; tied 0 unless the macro in Configuration is defined.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all `cmd_*` fields and go to EXEC.
- EXEC (exactly one cycle):
  - ALU op: drive `alu_a`=reg[ra], `alu_b`=reg[rb], `alu_control`=op, `alu_flag_in`=flag.
  - At the end of the cycle, write `alu_result` to reg[rd] and register `alu_result`, `alu_c` and `alu_z` into the response registers.
  - LOAD: the ALU outputs are driven 0. Write `cmd_imm` to reg[rd]; response result=imm, C=0, Z=(imm==0).
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; all `rsp_*` values are held stable.
  - Go to IDLE on `rsp_ready`.
- Outside EXEC, all `alu_*` outputs are 0.
- ra, rb and rd may be equal. Operands are read before the write (read-before-write within EXEC).
- Illegal opcode with the macro undefined: treated as an ALU op. The ALU default returns 0, which is written to reg[rd].

## Timing
- Command accepted at edge N.
  - EXEC occupies cycle N+1.
  - Register write and response registers update at edge N+2.
  - `rsp_valid`=1 from cycle N+2.
- Minimum period is 3 cycles per command with `rsp_ready` held high.
- `cmd_ready` is 0 in EXEC and RESP. There is no overlap between commands.
- The `alu_*` inputs are sampled only at the end of EXEC; the ALU is combinational and has one cycle to settle.
- Reset values: state=IDLE, all registers 0, `cmd_ready`=1, `rsp_valid`=0, `rsp_result`/`rsp_c`/`rsp_z`/`rsp_err`=0, `alu_*`=0.
- Reset in any state, including EXEC or RESP:
  - Takes effect at the next edge.
  - The in-flight command is dropped with no write and no response.
  - The register file clears.
- `rsp_valid` stays high indefinitely while `rsp_ready`=0.

## Configuration
- Macro `ALU_SEQ_ERR_EN`.
- Defined:
  - Opcodes 'hA–'hE are illegal.
  - EXEC performs no register write and drives the ALU outputs to 0.
  - The response carries result=0, C=0, Z=0, `rsp_err`=1.
  - `rsp_err`=0 for legal opcodes.
- Undefined: `rsp_err` is constant 0, and illegal opcodes behave as described in Operation.

## Structure
- Package `alu_seq_pkg` contains:
  - State enum `alu_seq_state_t` (IDLE, EXEC, RESP).
  - Opcode constants `OP_AND`..`OP_SHR` (0–9), `OP_LOAD`='hF, `OP_MAX_ALU`=9.
  - Register index width constant (2).
  - Packed command struct typedef.
- Sub-module `alu_seq_regfile` provides:
  - 4×WIDTH entries.
  - Two combinational read ports and one write port.
  - Synchronous active-high clear.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold `rst` 2 cycles -> `cmd_ready`=1, `rsp_valid`=0, all `alu_*`=0; an XOR of r0,r1 afterwards -> result 0, Z=1.
- LOAD r1=5, LOAD r2=3, then op0 (AND) rd=r3 ra=r1 rb=r2 -> `alu_a`=5 and `alu_b`=3 during EXEC; rsp_result=1, Z=0; reg r3=1. `rsp_valid` rises exactly 2 cycles after acceptance.
- op3 (increment) flag=1 rd=r2 ra=r1 rb=r2 with r2=3 -> `alu_flag_in`=1 during EXEC; rsp_result=4; a following LOAD-free read via op1 (OR) r2,r2 returns 4.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after completion -> `rsp_valid` and `rsp_result` stay constant and `cmd_ready`=0. Raise `rsp_ready` -> IDLE next cycle and `cmd_ready`=1.
- Illegal op 'hA with rd=r1 (r1=5):
  - With `ALU_SEQ_ERR_EN` -> `rsp_err`=1, result 0, r1 stays 5.
  - Without -> `rsp_err`=0, r1=0.
- Assert `rst` during EXEC of an AND command -> no response is produced, the FSM is in IDLE the cycle after reset, and r3 reads 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Optional illegal-opcode reporting is enabled with ALU_SEQ_ERR_EN.
package alu_seq_pkg;

  localparam int REG_AW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_seq_state_t;

  localparam logic [3:0] OP_AND     = 4'd0;
  localparam logic [3:0] OP_OR      = 4'd1;
  localparam logic [3:0] OP_XOR     = 4'd2;
  localparam logic [3:0] OP_INC     = 4'd3;
  localparam logic [3:0] OP_DEC     = 4'd4;
  localparam logic [3:0] OP_ADD     = 4'd5;
  localparam logic [3:0] OP_SUB     = 4'd6;
  localparam logic [3:0] OP_NOT     = 4'd7;
  localparam logic [3:0] OP_SHL     = 4'd8;
  localparam logic [3:0] OP_SHR     = 4'd9;
  localparam logic [3:0] OP_MAX_ALU = 4'd9;
  localparam logic [3:0] OP_LOAD    = 4'hF;

  typedef struct packed {
    logic [3:0]        op;
    logic              flag;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
  } alu_seq_cmd_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// 4-entry register file: two async read ports, one write port,
// synchronous active-high clear.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem [4];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer driving an external combinational ALU.
// Define ALU_SEQ_ERR_EN to reject opcodes 'hA-'hE with rsp_err.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_flag,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_ra,
  input  logic [1:0]       cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  output logic             alu_flag_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             rsp_err
);

  alu_seq_state_t   state;
  alu_seq_cmd_t     cmd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] wdata;
  logic             is_load;
  logic             illegal;
  logic             alu_go;
  logic             we;
  logic [WIDTH-1:0] res_n;
  logic             c_n;
  logic             z_n;

  alu_seq_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk     (clk),
    .clr     (rst),
    .we      (we),
    .waddr   (cmd_q.rd),
    .wdata   (wdata),
    .raddr_a (cmd_q.ra),
    .raddr_b (cmd_q.rb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    is_load = (cmd_q.op == OP_LOAD);
`ifdef ALU_SEQ_ERR_EN
    illegal = !is_load && (cmd_q.op > OP_MAX_ALU);
`else
    illegal = 1'b0;
`endif
    alu_go = (state == EXEC) && !is_load && !illegal;
    we     = (state == EXEC) && !illegal;
    wdata  = is_load ? imm_q : alu_result;
    res_n  = alu_result;
    c_n    = alu_c;
    z_n    = alu_z;
    unique case (1'b1)
      is_load: begin
        res_n = imm_q;
        c_n   = 1'b0;
        z_n   = (imm_q == '0);
      end
      illegal: begin
        res_n = '0;
        c_n   = 1'b0;
        z_n   = 1'b0;
      end
      default: ;
    endcase
  end

  assign cmd_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign alu_a       = alu_go ? rd_a : '0;
  assign alu_b       = alu_go ? rd_b : '0;
  assign alu_control = alu_go ? cmd_q.op : 4'd0;
  assign alu_flag_in = alu_go & cmd_q.flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      imm_q      <= '0;
      rsp_result <= '0;
      rsp_c      <= 1'b0;
      rsp_z      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q.op   <= cmd_op;
            cmd_q.flag <= cmd_flag;
            cmd_q.rd   <= cmd_rd;
            cmd_q.ra   <= cmd_ra;
            cmd_q.rb   <= cmd_rb;
            imm_q      <= cmd_imm;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= res_n;
          rsp_c      <= c_n;
          rsp_z      <= z_n;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == EXEC) begin
      err_q <= illegal;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural ALU and a response scoreboard.
// Expectations follow ALU_SEQ_ERR_EN when it is defined.
module tb_alu_seq_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = '0;
  logic         cmd_flag = 1'b0;
  logic [1:0]   cmd_rd = '0;
  logic [1:0]   cmd_ra = '0;
  logic [1:0]   cmd_rb = '0;
  logic [W-1:0] cmd_imm = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_control;
  logic         alu_flag_in;
  logic [W-1:0] alu_result;
  logic         alu_c;
  logic         alu_z;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_c;
  logic         rsp_z;
  logic         rsp_err;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [W-1:0] mreg [4];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_flag(cmd_flag),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_flag_in(alu_flag_in),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_c(rsp_c), .rsp_z(rsp_z),
    .rsp_err(rsp_err)
  );

  // Lab ALU behaviour: returns {carry, result}
  function automatic logic [W:0] alu_fn(
    input logic [3:0] op, input logic [W-1:0] a,
    input logic [W-1:0] b, input logic f);
    logic [W:0] r;
    case (op)
      4'd0: r = {1'b0, a & b};
      4'd1: r = {1'b0, a | b};
      4'd2: r = {1'b0, a ^ b};
      4'd3: r = {1'b0, b} + {{W{1'b0}}, f};
      4'd4: r = {1'b0, a} - {{W{1'b0}}, 1'b1};
      4'd5: r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, f};
      4'd6: r = {1'b0, a} - {1'b0, b};
      4'd7: r = {1'b0, ~a};
      4'd8: r = {a, 1'b0};
      4'd9: r = {a[0], 1'b0, a[W-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    {alu_c, alu_result} = alu_fn(alu_control, alu_a, alu_b, alu_flag_in);
    alu_z = (alu_result == '0);
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got res=%0d err=%0d expected none",
                 rsp_result, rsp_err);
      end else begin
        e = sb.pop_front();
        if ({rsp_result, rsp_c, rsp_z, rsp_err} !== e) begin
          bad++;
          $display("FAIL rsp got res=%0d c=%0d z=%0d err=%0d exp res=%0d c=%0d z=%0d err=%0d",
                   rsp_result, rsp_c, rsp_z, rsp_err, e.res, e.c, e.z, e.err);
        end
      end
    end
  end

  // Drives one command, records its expected response and returns
  // 1 time unit after the accepting edge (start of EXEC).
  task automatic issue(input logic [3:0] op, input logic f,
                       input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [W-1:0] imm);
    exp_t e;
    logic [W:0] cr;
    int n;
    logic ill;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL cmd_ready_timeout got 0 expected 1");
    end
    ill = (op > 4'd9) && (op != 4'hF);
    if (op == 4'hF) begin
      e = '{res: imm, c: 1'b0, z: (imm == '0), err: 1'b0};
      mreg[rd] = imm;
    end else begin
`ifdef ALU_SEQ_ERR_EN
      if (ill) begin
        e = '{res: '0, c: 1'b0, z: 1'b0, err: 1'b1};
      end else begin
`endif
        cr = alu_fn(op, mreg[ra], mreg[rb], f);
        e = '{res: cr[W-1:0], c: cr[W], z: (cr[W-1:0] == '0), err: 1'b0};
        mreg[rd] = cr[W-1:0];
`ifdef ALU_SEQ_ERR_EN
      end
`endif
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_op = op; cmd_flag = f; cmd_rd = rd;
    cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (ill) cmd_imm = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_hs got rdy=%0d vld=%0d expected rdy=1 vld=0",
               cmd_ready, rsp_valid);
    end
    total++;
    if ({alu_a, alu_b, alu_control, alu_flag_in} !== '0) begin
      bad++;
      $display("FAIL reset_alu got a=%0d b=%0d ctl=%0d f=%0d expected 0",
               alu_a, alu_b, alu_control, alu_flag_in);
    end
    total++;
    if ({rsp_result, rsp_c, rsp_z, rsp_err} !== '0) begin
      bad++;
      $display("FAIL reset_rsp got res=%0d c=%0d z=%0d err=%0d expected 0",
               rsp_result, rsp_c, rsp_z, rsp_err);
    end
    issue(4'd2, 1'b0, 2'd0, 2'd0, 2'd1, '0);
    drain();
  endtask

  task automatic test_and();
    issue(4'hF, 1'b0, 2'd1, 2'd0, 2'd0, 4'd5);
    issue(4'hF, 1'b0, 2'd2, 2'd0, 2'd0, 4'd3);
    issue(4'd0, 1'b0, 2'd3, 2'd1, 2'd2, '0);
    @(negedge clk);
    total++;
    if ({alu_a, alu_b, alu_control} !== {4'd5, 4'd3, 4'd0}) begin
      bad++;
      $display("FAIL and_exec got a=%0d b=%0d ctl=%0d expected a=5 b=3 ctl=0",
               alu_a, alu_b, alu_control);
    end
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL and_exec_hs got vld=%0d rdy=%0d expected 0 0",
               rsp_valid, cmd_ready);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL and_latency got vld=%0d expected 1", rsp_valid);
    end
    drain();
    issue(4'd1, 1'b0, 2'd0, 2'd3, 2'd3, '0);
    drain();
  endtask

  task automatic test_inc();
    issue(4'd3, 1'b1, 2'd2, 2'd1, 2'd2, '0);
    @(negedge clk);
    total++;
    if ({alu_flag_in, alu_control, alu_b} !== {1'b1, 4'd3, 4'd3}) begin
      bad++;
      $display("FAIL inc_exec got f=%0d ctl=%0d b=%0d expected f=1 ctl=3 b=3",
               alu_flag_in, alu_control, alu_b);
    end
    drain();
    issue(4'd1, 1'b0, 2'd2, 2'd2, 2'd2, '0);
    drain();
    total++;
    if (mreg[2] !== 4'd4) begin
      bad++;
      $display("FAIL inc_model got %0d expected 4", mreg[2]);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(4'hF, 1'b0, 2'd0, 2'd0, 2'd0, 4'd7);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_result, cmd_ready} !== {1'b1, 4'd7, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d got vld=%0d res=%0d rdy=%0d expected 1 7 0",
                 i, rsp_valid, rsp_result, cmd_ready);
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release got rdy=%0d vld=%0d expected 1 0",
               cmd_ready, rsp_valid);
    end
    drain();
  endtask

  task automatic test_illegal();
    issue(4'hA, 1'b0, 2'd1, 2'd1, 2'd2, '0);
    @(negedge clk);
    total++;
`ifdef ALU_SEQ_ERR_EN
    if (alu_control !== 4'd0) begin
`else
    if (alu_control !== 4'hA) begin
`endif
      bad++;
      $display("FAIL illegal_exec_ctl got %0d", alu_control);
    end
    drain();
    issue(4'd1, 1'b0, 2'd0, 2'd1, 2'd1, '0);
    drain();
  endtask

  task automatic test_reset_exec();
    int n;
    issue(4'hF, 1'b0, 2'd3, 2'd0, 2'd0, 4'd9);
    drain();
    issue(4'd0, 1'b0, 2'd3, 2'd1, 2'd2, '0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rst_exec_state got rdy=%0d vld=%0d expected 1 0",
               cmd_ready, rsp_valid);
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL rst_exec_norsp got %0d valid cycles expected 0", n);
    end
    issue(4'd1, 1'b0, 2'd0, 2'd3, 2'd3, '0);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    test_reset();
    test_and();
    test_inc();
    test_backpressure();
    test_illegal();
    test_reset_exec();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
